// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and the control-unit decoder.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam int unsigned INSTR_WIDTH      = 32;
   localparam int unsigned OPCODE_WIDTH     = 7;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      RType       = 7'b0110011,
      Load        = 7'b0000011,
      IType       = 7'b0010011,
      SType       = 7'b0100011,
      BType       = 7'b1100011,
      AddUpp      = 7'b0010111,
      LoadUpp     = 7'b0110111,
      JumpLink    = 7'b1101111,
      JumpLinkReg = 7'b1100111
   } opcode_e;

   typedef enum logic {
      FETCH = 1'b0,
      KILL  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry synchronous FIFO holding {instr, pc} words between fetch and decode.
module fetch_skid_fifo #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// hands {instr, pc} to decode through a 2-entry skid FIFO with redirect flush.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   output logic                    imem_req_o,
   output logic [ADDR_WIDTH-1:0]   imem_addr_o,
   input  logic [INSTR_WIDTH-1:0]  imem_rdata_i,
   input  logic                    redirect_i,
   input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic [INSTR_WIDTH-1:0]  instr_o,
   output logic [OPCODE_WIDTH-1:0] opcode_o,
   output logic [ADDR_WIDTH-1:0]   pc_o,
   output logic [ADDR_WIDTH-1:0]   pc_plus4_o
);

   localparam int unsigned ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] issued_pc_q, issued_pc_d;
   logic                  inflight_q, inflight_d;
   fetch_state_e          state_q, state_d;

   logic [1:0]            count;
   logic [2:0]            occupancy;
   logic                  pop, push, flush, issue;
   logic [ENTRY_W-1:0]    head;

   // Issue only when the word it returns is guaranteed a FIFO slot.
   always_comb begin
      pop         = valid_o && ready_i;
      occupancy   = 3'(count) + 3'(inflight_q) - 3'(pop);
      issue       = !rst_i && !redirect_i && (occupancy < 3'd2);

      fetch_pc_d  = fetch_pc_q;
      issued_pc_d = issued_pc_q;
      inflight_d  = 1'b0;
      state_d     = FETCH;
      flush       = 1'b0;
      push        = (state_q == FETCH) && inflight_q;

      if (issue) begin
         fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(4);
         issued_pc_d = fetch_pc_q;
         inflight_d  = 1'b1;
      end

      if (redirect_i) begin
         flush      = 1'b1;
         push       = 1'b0;
         fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
         state_d    = inflight_q ? KILL : FETCH;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q  <= RESET_PC;
         issued_pc_q <= '0;
         inflight_q  <= 1'b0;
         state_q     <= FETCH;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         issued_pc_q <= issued_pc_d;
         inflight_q  <= inflight_d;
         state_q     <= state_d;
      end
   end

   fetch_skid_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .data_i  ({imem_rdata_i, issued_pc_q}),
      .data_o  (head),
      .count_o (count)
   );

   assign valid_o     = (count != 2'd0);
   assign imem_req_o  = issue;
   assign imem_addr_o = fetch_pc_q;
   assign instr_o     = head[ENTRY_W-1 -: INSTR_WIDTH];
   assign pc_o        = head[ADDR_WIDTH-1:0];
   assign opcode_o    = instr_o[OPCODE_WIDTH-1:0];
   assign pc_plus4_o  = pc_o + ADDR_WIDTH'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory model returns the address as data.
module tb_instr_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] instr_o;
   logic [6:0]  opcode_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_pc;

   instr_fetch_unit dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .instr_o       (instr_o),
      .opcode_o      (opcode_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      imem_rdata_i <= imem_req_o ? imem_addr_o : 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", imem_addr_o, 32'hBFC0_0000);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_opcode", 32'(opcode_o), 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_pc_plus4", pc_plus4_o, 32'd4);
   endtask

   // With ready_i high, expect one consecutive word per cycle starting at exp_pc.
   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         chk("stream_valid", 32'(valid_o), 32'd1);
         chk("stream_pc", pc_o, exp_pc);
         chk("stream_instr", instr_o, exp_pc);
         chk("stream_opcode", 32'(opcode_o), {25'd0, exp_pc[6:0]});
         chk("stream_pc_plus4", pc_plus4_o, exp_pc + 32'd4);
         exp_pc = exp_pc + 32'd4;
         tick();
      end
   endtask

   initial begin
      rst_i         = 1'b1;
      ready_i       = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'd0;
      repeat (3) tick();
      chk_reset_outputs();

      // Cycle 0: first request at RESET_PC.
      rst_i = 1'b0;
      #1;
      chk("c0_req", 32'(imem_req_o), 32'd1);
      chk("c0_addr", imem_addr_o, 32'hBFC0_0000);
      chk("c0_valid", 32'(valid_o), 32'd0);
      tick();
      #1;
      chk("c1_valid", 32'(valid_o), 32'd0);
      chk("c1_req", 32'(imem_req_o), 32'd1);
      chk("c1_addr", imem_addr_o, 32'hBFC0_0004);
      tick();
      exp_pc = 32'hBFC0_0000;
      stream(1);

      // Backpressure from cycle 3 for 10 cycles.
      ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("hold_valid", 32'(valid_o), 32'd1);
         chk("hold_pc", pc_o, exp_pc);
         chk("hold_instr", instr_o, exp_pc);
         chk("hold_req", 32'(imem_req_o), 32'd0);
         tick();
      end
      ready_i = 1'b1;
      stream(6);

      // Redirect to unaligned target with a word buffered and a response in flight.
      ready_i       = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      #1;
      chk("redir_req", 32'(imem_req_o), 32'd0);
      tick();
      redirect_i = 1'b0;
      ready_i    = 1'b1;
      #1;
      chk("redir_n1_valid", 32'(valid_o), 32'd0);
      chk("redir_n1_req", 32'(imem_req_o), 32'd1);
      chk("redir_n1_addr", imem_addr_o, 32'h0000_0100);
      tick();
      chk("redir_n2_valid", 32'(valid_o), 32'd0);
      tick();
      exp_pc = 32'h0000_0100;
      stream(4);

      // Back-to-back redirects: only the second target's stream may appear.
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0040;
      #1;
      chk("b2b_first_req", 32'(imem_req_o), 32'd0);
      tick();
      redirect_pc_i = 32'h0000_0080;
      #1;
      chk("b2b_second_req", 32'(imem_req_o), 32'd0);
      chk("b2b_second_valid", 32'(valid_o), 32'd0);
      tick();
      redirect_i = 1'b0;
      #1;
      chk("b2b_valid_a", 32'(valid_o), 32'd0);
      chk("b2b_addr", imem_addr_o, 32'h0000_0080);
      chk("b2b_req", 32'(imem_req_o), 32'd1);
      tick();
      chk("b2b_valid_b", 32'(valid_o), 32'd0);
      tick();
      exp_pc = 32'h0000_0080;
      stream(3);

      // PC wrap across the top of the address space.
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFF8;
      tick();
      redirect_i = 1'b0;
      tick();
      tick();
      exp_pc = 32'hFFFF_FFF8;
      stream(4);

      // Reset together with redirect mid-stream.
      rst_i         = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      #1;
      chk("rst_mid_req", 32'(imem_req_o), 32'd0);
      tick();
      chk_reset_outputs();
      rst_i      = 1'b0;
      redirect_i = 1'b0;
      #1;
      chk("restart_req", 32'(imem_req_o), 32'd1);
      chk("restart_addr", imem_addr_o, 32'hBFC0_0000);
      chk("restart_valid", 32'(valid_o), 32'd0);
      tick();
      tick();
      exp_pc = 32'hBFC0_0000;
      stream(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
